mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MEM pipeline stage of the 5-stage LoongArch core, between EX and WB. Registers the EX result bus,
//   aligns and sign/zero-extends load data returned by the data SRAM, and produces the 167-bit bus
//   consumed by WB. Also drives the ID forwarding/hazard bus and the EX store-suppress bit; killed by
//   WB exception or ertn flush.
// PARAMETERS
//   none; bus widths are fixed constants from the shared package (EX2MEM_W=175, MEM2WB_W=167, MEM2ID_W=39).
// PORTS
//   clk                input   1    clock
//   resetn             input   1    synchronous, active-low reset
//   mem_allowin        output  1    MEM can accept from EX this cycle
//   ex_to_mem_valid    input   1    EX presents a valid instruction
//   ex_to_mem_bus      input   175  {res_from_mem, ld_op[4:0], addr_lo[1:0], <167-bit WB field set>}
//   wb_allowin         input   1    WB can accept
//   mem_to_wb_valid    output  1    valid toward WB
//   mem_to_wb_bus      output  167  {rf_we,rf_waddr[4:0],rf_wdata[31:0],pc[31:0],csr_re,csr_we,csr_num[13:0],
//                                    csr_wmask[31:0],csr_wvalue[31:0],ertn,excep_en,ecode[5:0],esubcode[8:0]}
//   data_sram_rdata    input   32   load data; valid in the cycle the load occupies MEM
//   mem_to_id_bus      output  39   {rf_we&valid, rf_waddr, final_wdata, csr_re&valid}
//   mem_to_ex_bus      output  1    (excep_en|ertn)&mem_valid; EX must not issue stores
//   wb_ex              input   1    exception taken in WB
//   ertn_flush         input   1    ertn retiring in WB
// BEHAVIOUR
//   - flush = wb_ex | ertn_flush. ready_go = 1 (SRAM data arrives the cycle after EX request).
//   - mem_allowin = ~mem_valid | (wb_allowin); mem_to_wb_valid = mem_valid & ~flush.
//   - mem_valid: reset->0; else if flush ->0; else if mem_allowin -> ex_to_mem_valid.
//   - Payload regs load on ex_to_mem_valid & mem_allowin & ~flush; hold otherwise. Reset clears all to 0.
//   - Reset dominates flush; flush dominates capture in the same cycle.
//   - ld_op one-hot {w,hu,h,bu,b}. Byte = rdata[8*addr_lo+:8]; half = rdata[16*addr_lo[1]+:16].
//     b/h sign-extend, bu/hu zero-extend, w passes rdata. Non-one-hot ld_op with res_from_mem -> result 0.
//   - final_wdata = res_from_mem ? aligned_load : rf_wdata (reg). Bus field rf_wdata carries final_wdata.
//   - excep_en set: outgoing rf_we forced 0 in both mem_to_wb_bus and mem_to_id_bus; fields else passed.
//   - All other 167-bit fields pass through unchanged; csr read value is NOT resolved here (WB does it).
//   - Outputs after reset: mem_allowin=1, mem_to_wb_valid=0, mem_to_id_bus=0, mem_to_ex_bus=0,
//     mem_to_wb_bus=0 except rf_wdata=0 (data-driven when res_from_mem=0).
//   - Latency: one cycle EX->MEM register; MEM->WB combinational handoff.
//   - Back-pressure: wb_allowin=0 with mem_valid=1 -> registers and outputs stable; SRAM rdata must be
//     re-held by EX/SRAM contract is NOT assumed: rdata captured into a hold register on the first MEM
//     cycle and used while stalled.
// STRUCTURE
//   - Package cpu_pkg: EX2MEM_W, MEM2WB_W, MEM2ID_W, LD_B..LD_W one-hot indices, field offset localparams.
//   - Sub-module mem_load_align (combinational): rdata, addr_lo, ld_op -> 32-bit aligned result.
//   - Top: valid/flush control, payload regs, rdata hold reg + first-cycle flag, bus assembly.
// TESTING
//   - ld.b addr_lo=3, rdata=0x80FF1234 -> WB rf_wdata=0xFFFFFF80, rf_we=1.
//   - ld.hu addr_lo=2, rdata=0x80FF1234 -> 0x000080FF; ld.h addr_lo=0 -> 0x00001234.
//   - ALU op rf_wdata=0xDEADBEEF, res_from_mem=0 -> passes; mem_to_id_bus={1,waddr,0xDEADBEEF,0}.
//   - Load in MEM, wb_allowin=0 for 3 cycles, SRAM rdata changed -> output holds original aligned value.
//   - wb_ex=1 with valid MEM instr -> mem_to_wb_valid=0 same cycle, mem_valid=0 next; EX capture dropped.
//   - excep_en=1 (ecode 0x09 ALE) -> rf_we=0 on both buses, mem_to_ex_bus=1; resetn=0 mid-stall -> all 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared bus widths, load-op indices and MEM-stage bus field offsets
package cpu_pkg;
    localparam int EX2MEM_W = 175;
    localparam int MEM2WB_W = 167;
    localparam int MEM2ID_W = 39;
    localparam int LD_OP_W  = 5;
    localparam int LD_B  = 0;
    localparam int LD_BU = 1;
    localparam int LD_H  = 2;
    localparam int LD_HU = 3;
    localparam int LD_W  = 4;
    localparam int EX_RES_FROM_MEM = 174;
    localparam int EX_LD_OP        = 169;
    localparam int EX_ADDR_LO      = 167;
    localparam int WB_RF_WE    = 166;
    localparam int WB_RF_WADDR = 161;
    localparam int WB_RF_WDATA = 129;
    localparam int WB_CSR_RE   = 96;
    localparam int WB_ERTN     = 16;
    localparam int WB_EXCEP    = 15;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects and extends the loaded byte/half/word from the SRAM read word
module mem_load_align
    import cpu_pkg::*;
(
    input  logic [31:0]        rdata,
    input  logic [1:0]         addr_lo,
    input  logic [LD_OP_W-1:0] ld_op,
    output logic [31:0]        result
);
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    assign byte_d = rdata[{addr_lo, 3'b000} +: 8];
    assign half_d = rdata[{addr_lo[1], 4'b0000} +: 16];
    // extension follows the one-hot load type; a malformed op returns zero
    always_comb begin
        result = !$onehot(ld_op) ? 32'h0 :
                 ld_op[LD_B]     ? {{24{byte_d[7]}}, byte_d} :
                 ld_op[LD_BU]    ? {24'h0, byte_d} :
                 ld_op[LD_H]     ? {{16{half_d[15]}}, half_d} :
                 ld_op[LD_HU]    ? {16'h0, half_d} :
                 rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; registers EX result, aligns load data, feeds WB/ID/EX
module mem_stage
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    output logic                mem_allowin,
    input  logic                ex_to_mem_valid,
    input  logic [EX2MEM_W-1:0] ex_to_mem_bus,
    input  logic                wb_allowin,
    output logic                mem_to_wb_valid,
    output logic [MEM2WB_W-1:0] mem_to_wb_bus,
    input  logic [31:0]         data_sram_rdata,
    output logic [MEM2ID_W-1:0] mem_to_id_bus,
    output logic                mem_to_ex_bus,
    input  logic                wb_ex,
    input  logic                ertn_flush
);
    logic                flush;
    logic                mem_valid;
    logic                capture;
    logic                first_cycle;
    logic                out_we;
    logic [EX2MEM_W-1:0] ex_bus_r;
    logic [MEM2WB_W-1:0] wb_f;
    logic [31:0]         rdata_hold;
    logic [31:0]         rdata_use;
    logic [31:0]         load_res;
    logic [31:0]         final_wdata;

    assign flush           = wb_ex | ertn_flush;
    assign mem_allowin     = ~mem_valid | wb_allowin;
    assign capture         = ex_to_mem_valid & mem_allowin & ~flush;
    assign mem_to_wb_valid = mem_valid & ~flush;

    // occupancy: reset beats flush, flush beats refill from EX
    always_ff @(posedge clk) begin
        if (!resetn)
            mem_valid <= 1'b0;
        else if (flush)
            mem_valid <= 1'b0;
        else if (mem_allowin)
            mem_valid <= ex_to_mem_valid;
    end

    // payload register holds the EX bus for the whole MEM residency
    always_ff @(posedge clk) begin
        if (!resetn)
            ex_bus_r <= '0;
        else if (capture)
            ex_bus_r <= ex_to_mem_bus;
    end

    // SRAM data is only guaranteed in the first MEM cycle, so keep a copy for stalls
    always_ff @(posedge clk) begin
        if (!resetn) begin
            first_cycle <= 1'b0;
            rdata_hold  <= '0;
        end else begin
            first_cycle <= capture;
            if (first_cycle)
                rdata_hold <= data_sram_rdata;
        end
    end

    assign rdata_use = first_cycle ? data_sram_rdata : rdata_hold;

    mem_load_align u_align (
        .rdata   (rdata_use),
        .addr_lo (ex_bus_r[EX_ADDR_LO +: 2]),
        .ld_op   (ex_bus_r[EX_LD_OP +: LD_OP_W]),
        .result  (load_res)
    );

    assign wb_f        = ex_bus_r[MEM2WB_W-1:0];
    assign final_wdata = ex_bus_r[EX_RES_FROM_MEM] ? load_res : wb_f[WB_RF_WDATA +: 32];
    assign out_we      = wb_f[WB_RF_WE] & ~wb_f[WB_EXCEP];

    assign mem_to_wb_bus = {out_we, wb_f[WB_RF_WADDR +: 5], final_wdata, wb_f[WB_RF_WDATA-1:0]};
    assign mem_to_id_bus = {out_we & mem_valid, wb_f[WB_RF_WADDR +: 5], final_wdata,
                            wb_f[WB_CSR_RE] & mem_valid};
    assign mem_to_ex_bus = (wb_f[WB_EXCEP] | wb_f[WB_ERTN]) & mem_valid;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a behavioural load model
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         mem_allowin;
    logic         ex_to_mem_valid = 1'b0;
    logic [174:0] ex_to_mem_bus = '0;
    logic         wb_allowin = 1'b1;
    logic         mem_to_wb_valid;
    logic [166:0] mem_to_wb_bus;
    logic [31:0]  data_sram_rdata = '0;
    logic [38:0]  mem_to_id_bus;
    logic         mem_to_ex_bus;
    logic         wb_ex = 1'b0;
    logic         ertn_flush = 1'b0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .wb_allowin      (wb_allowin),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_id_bus   (mem_to_id_bus),
        .mem_to_ex_bus   (mem_to_ex_bus),
        .wb_ex           (wb_ex),
        .ertn_flush      (ertn_flush)
    );

    typedef struct {
        logic [166:0] wb;
        logic [38:0]  id;
        logic         ex;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic        mv_m = 1'b0;
    logic        acc_flag = 1'b0;
    logic        post_rst = 1'b0;
    logic [31:0] pend_rdata = '0;
    logic [31:0] acc_rdata = '0;

    task automatic chk(input string n, input logic [166:0] act, input logic [166:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // load result from the ISA rules: pick byte/half by address, extend by type
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] b = (d >> (8 * a)) & 32'hFF;
        logic [31:0] h = (d >> (16 * (a / 2))) & 32'hFFFF;
        if (op == 5'b00001) return (b ^ 32'h80) - 32'h80;
        if (op == 5'b00010) return b;
        if (op == 5'b00100) return (h ^ 32'h8000) - 32'h8000;
        if (op == 5'b01000) return h;
        if (op == 5'b10000) return d;
        return 32'h0;
    endfunction

    function automatic exp_t mk_exp(input logic [174:0] b, input logic [31:0] d);
        exp_t        e;
        logic [166:0] w = b[166:0];
        logic         we = w[166] & ~w[15];
        logic [31:0]  fw = b[174] ? ref_load(b[173:169], b[168:167], d) : w[160:129];
        e.wb = {we, w[165:161], fw, w[128:0]};
        e.id = {we, w[165:161], fw, w[96]};
        e.ex = w[15] | w[16];
        return e;
    endfunction

    function automatic logic [174:0] mk(input logic res, input logic [4:0] op, input logic [1:0] a,
                                        input logic [31:0] wd, input logic exc, input logic er);
        logic [174:0] b = {$urandom, $urandom, $urandom, $urandom, $urandom, 15'($urandom)};
        b[174]     = res;
        b[173:169] = op;
        b[168:167] = a;
        b[166]     = 1'b1;
        b[160:129] = wd;
        b[16]      = er;
        b[15]      = exc;
        if (exc) b[14:9] = 6'h09;
        return b;
    endfunction

    function automatic logic [4:0] rnd_op();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
    endfunction

    task automatic drive(input logic ev, input logic [174:0] b, input logic [31:0] rd,
                         input logic wa, input logic wx, input logic ef);
        @(posedge clk);
        #1;
        data_sram_rdata = acc_flag ? acc_rdata : $urandom;
        pend_rdata      = rd;
        ex_to_mem_valid = ev;
        ex_to_mem_bus   = b;
        wb_allowin      = wa;
        wb_ex           = wx;
        ertn_flush      = ef;
    endtask

    // monitor: tracks stage occupancy, pops/compares expected results, pushes accepted ones
    initial begin
        logic acc;
        logic fl;
        forever begin
            @(negedge clk);
            if (post_rst) begin
                chk("rst_allowin", 167'(mem_allowin), 167'(1));
                chk("rst_valid", 167'(mem_to_wb_valid), 167'(0));
                chk("rst_wb_bus", mem_to_wb_bus, 167'(0));
                chk("rst_id_bus", 167'(mem_to_id_bus), 167'(0));
                chk("rst_ex_bus", 167'(mem_to_ex_bus), 167'(0));
                post_rst = 1'b0;
            end
            if (resetn) begin
                fl = wb_ex | ertn_flush;
                chk("allowin", 167'(mem_allowin), 167'(!mv_m || wb_allowin));
                chk("wb_valid", 167'(mem_to_wb_valid), 167'(mv_m && !fl));
                if (mv_m && q.size() > 0) begin
                    chk("wb_bus", mem_to_wb_bus, q[0].wb);
                    chk("id_bus", 167'(mem_to_id_bus), 167'(q[0].id));
                    chk("ex_bus", 167'(mem_to_ex_bus), 167'(q[0].ex));
                    if (fl || wb_allowin) void'(q.pop_front());
                end
                acc = ex_to_mem_valid && (!mv_m || wb_allowin) && !fl;
                if (acc) begin
                    q.push_back(mk_exp(ex_to_mem_bus, pend_rdata));
                    acc_rdata = pend_rdata;
                end
                acc_flag = acc;
                mv_m = fl ? 1'b0 : (!mv_m || wb_allowin) ? ex_to_mem_valid : mv_m;
            end else begin
                q.delete();
                mv_m     = 1'b0;
                acc_flag = 1'b0;
                post_rst = 1'b1;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        drive(1, mk(1, 5'b00001, 2'd3, 32'h0, 0, 0), 32'h80FF1234, 1, 0, 0);
        drive(1, mk(1, 5'b01000, 2'd2, 32'h0, 0, 0), 32'h80FF1234, 1, 0, 0);
        drive(1, mk(1, 5'b00100, 2'd0, 32'h0, 0, 0), 32'h80FF1234, 1, 0, 0);
        drive(1, mk(0, 5'b00000, 2'd0, 32'hDEADBEEF, 0, 0), 32'h0, 1, 0, 0);
        drive(1, mk(1, 5'b00010, 2'd1, 32'h0, 0, 0), 32'hCAFEF00D, 1, 0, 0);
        repeat (3) drive(0, '0, 32'h0, 0, 0, 0);
        drive(0, '0, 32'h0, 1, 0, 0);
        drive(1, mk(0, 5'b00000, 2'd0, 32'h12345678, 0, 0), 32'h0, 1, 0, 0);
        drive(1, mk(1, 5'b10000, 2'd0, 32'h0, 0, 0), 32'h11112222, 1, 1, 0);
        drive(1, mk(0, 5'b00000, 2'd0, 32'h0BADF00D, 0, 0), 32'h0, 1, 0, 1);
        drive(1, mk(1, 5'b00011, 2'd0, 32'h0, 0, 0), 32'hFFFFFFFF, 1, 0, 0);
        drive(1, mk(0, 5'b00000, 2'd0, 32'h55AA55AA, 1, 0), 32'h0, 1, 0, 0);
        drive(0, '0, 32'h0, 1, 0, 0);
        repeat (3000)
            drive($urandom_range(0, 3) != 0,
                  mk(1'($urandom), rnd_op(), 2'($urandom), $urandom,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0),
                  $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        drive(1, mk(1, 5'b00001, 2'd0, 32'h0, 0, 0), 32'h00000080, 1, 0, 0);
        drive(0, '0, 32'h0, 0, 0, 0);
        drive(0, '0, 32'h0, 0, 0, 0);
        resetn = 1'b0;
        drive(0, '0, 32'h0, 0, 0, 0);
        resetn = 1'b1;
        repeat (4) drive(0, '0, 32'h0, 1, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
